lc3_decode_stage: RTL and testbench
===================================

// Module: lc3_decode_stage
// PURPOSE
//  Decode stage of the LC-3 pipeline. It sits directly upstream of regfile8x16.
//  - Accepts fetched instructions over a valid/ready handshake.
//  - Drives the register-file read addresses and captures the read data.
//  - Sign-extends immediates and tracks pending register writes in a scoreboard.
//  - Presents one registered decoded-operation record to execute, with valid/ready.
// PARAMETERS
//  DATA_W  16  datapath / instruction width
//  ADDR_W  3   register address width (8 GPRs)
// PORTS
//  clk           in   1       clock; all state updates on rising edge
//  rst           in   1       synchronous, active-high reset
//  in_valid      in   1       fetch presents instruction
//  in_ready      out  1       decode accepts instruction this cycle
//  in_instr      in   DATA_W  instruction word
//  in_pc         in   DATA_W  PC of in_instr (already incremented)
//  rdAddrA       out  ADDR_W  regfile read address A (combinational from in_instr)
//  rdAddrB       out  ADDR_W  regfile read address B (combinational from in_instr)
//  rdDataA       in   DATA_W  regfile read data A (combinational read)
//  rdDataB       in   DATA_W  regfile read data B (combinational read)
//  wb_writeEN    in   1       writeback writing regfile this cycle
//  wb_wrAddr     in   ADDR_W  writeback destination
//  flush         in   1       squash output record (taken branch/JMP/TRAP)
//  out_valid     out  1       decoded record valid
//  out_ready     in   1       execute accepts record
//  out_opcode    out  4       instr[15:12]
//  out_opA       out  DATA_W  source A value (rdDataA)
//  out_opB       out  DATA_W  rdDataB, or imm for ADD/AND with bit5=1
//  out_imm       out  DATA_W  extended immediate/offset (0 if none)
//  out_dest      out  ADDR_W  destination register
//  out_wen       out  1       record writes a GPR
//  out_setcc     out  1       record updates NZP (ADD,AND,NOT,LD,LDI,LDR)
//  out_nzp       out  3       BR condition bits instr[11:9]
//  out_pc        out  DATA_W  captured in_pc
//  out_illegal   out  1       opcode 1101 (reserved) or 1000 (RTI, unsupported)
// BEHAVIOUR
//  - Reset: out_valid=0, every out_* register=0, scoreboard busy[7:0]=0.
//    A reset asserted mid-operation drops the held record and all pending busy bits.
//  - Latency: an instruction accepted at edge N is on out_* after edge N with out_valid=1.
//  - Handshake:
//      in_ready = !rst & !flush & !hazard & (!out_valid | out_ready).
//      Accept = in_valid & in_ready. Record retires on out_valid & out_ready.
//      While out_valid & !out_ready, all out_* are held stable.
//  - Sources:
//      rdAddrA = instr[8:6].
//      rdAddrB = instr[2:0] for ADD/AND reg mode; instr[11:9] for ST/STI/STR.
//      usesA: ADD, AND, NOT, LDR, STR, JMP, JSRR.
//      usesB: ADD/AND with bit5=0, ST, STI, STR.
//  - Hazard: a used source s is hazardous when busy[s], or when
//    (out_valid & out_wen & out_dest==s). There is no bypass.
//    A source written by wb in the current cycle still stalls; it clears next cycle.
//  - Scoreboard:
//      busy[out_dest] is set on retire when out_wen=1.
//      busy[wb_wrAddr] is cleared on wb_writeEN.
//      Same register set and cleared in one cycle: set wins.
//  - Destination:
//      instr[11:9] for ADD, AND, NOT, LD, LDI, LDR, LEA.
//      R7 for JSR/JSRR/TRAP.
//      All others: out_wen=0, out_dest=0.
//  - Immediates (sign-extended unless noted):
//      imm5 for ADD/AND.
//      off6 for LDR/STR.
//      off9 for LD/LDI/LEA/ST/STI/BR.
//      off11 for JSR (bit11=1).
//      zext(trapvect8) for TRAP.
//  - Illegal opcode: out_illegal=1, out_wen=0, out_setcc=0; the record still passes.
//  - Flush:
//      out_valid<=0 at the next edge; in_ready=0 during flush.
//      busy is unchanged, because the squashed record never set a bit.
//      Flush together with out_ready: the record is not counted as retired.
// STRUCTURE
//  - lc3_pkg:
//      opcode enum (OP_BR..OP_TRAP).
//      IMM5/OFF6/OFF9/OFF11/TRAP8 width constants.
//      sext function.
//      decoded-record struct.
//  - Sub-module lc3_scoreboard:
//      8-bit busy vector with set/clr ports and set-wins priority.
//  - Decode logic is combinational into a single record register.
// TESTING
//  1. Hold rst 2 cycles -> out_valid=0, busy=0; in_ready=1 the cycle after release.
//  2. R1=5; send 0x147D (ADD R2,R1,#-3)
//     -> next cycle out_opA=5, out_opB=0xFFFD, out_dest=2, out_wen=1, out_setcc=1.
//  3. Retire 0x147D, then send 0x1682 (ADD R3,R2,R2)
//     -> in_ready=0 until wb_writeEN with wb_wrAddr=2; accepted the following cycle.
//  4. out_ready=0 for 3 cycles with a record held -> out_* stable, in_ready=0;
//     the record retires on the cycle out_ready=1.
//  5. flush=1 while out_valid=1 -> out_valid=0 next cycle, busy unchanged,
//     no instruction accepted in the flush cycle.
//  6. 0xF025 (TRAP x25) -> out_dest=7, out_wen=1, out_imm=0x0025.
//     0xD000 -> out_illegal=1, out_wen=0.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 decode definitions: opcodes, immediate field widths, the decoded
// record carried from decode to execute, and a sign-extension helper.
package lc3_pkg;

    localparam int WORD_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;

    localparam int IMM5_W  = 5;
    localparam int OFF6_W  = 6;
    localparam int OFF9_W  = 9;
    localparam int OFF11_W = 11;
    localparam int TRAP8_W = 8;

    localparam logic [REG_ADDR_W-1:0] LINK_REG = 3'd7;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RES  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } opcode_e;

    typedef struct packed {
        opcode_e                 opcode;
        logic [WORD_W-1:0]       op_a;
        logic [WORD_W-1:0]       op_b;
        logic [WORD_W-1:0]       imm;
        logic [REG_ADDR_W-1:0]   dest;
        logic                    wen;
        logic                    setcc;
        logic [2:0]              nzp;
        logic [WORD_W-1:0]       pc;
        logic                    illegal;
    } dec_rec_t;

    // Field must already sit in the low bits; shifting up then arithmetic
    // shifting back replicates its top bit.
    function automatic logic [WORD_W-1:0] sext(input logic [WORD_W-1:0] value,
                                               input int width);
        logic signed [WORD_W-1:0] shifted;
        shifted = $signed(value << (WORD_W - width));
        return shifted >>> (WORD_W - width);
    endfunction

endpackage

// File: rtl/lc3_scoreboard.sv
// Pending-write scoreboard: one busy bit per GPR, set when a writing record
// retires and cleared by writeback; a same-cycle set overrides the clear.
module lc3_scoreboard
    import lc3_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    output logic [NUM_REGS-1:0]   busy
);

    logic [NUM_REGS-1:0] busy_next;

    always_comb begin
        // NOTE: start from the current value so every path assigns busy_next; no latch.
        busy_next = busy;
        if (clr_en) busy_next[clr_addr] = 1'b0;
        if (set_en) busy_next[set_addr] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

endmodule

// File: rtl/lc3_decode_stage.sv
// LC-3 decode stage: reads the register file, builds one decoded record per
// accepted instruction and stalls on pending writes (no bypass).
module lc3_decode_stage
    import lc3_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_pc,
    output logic [ADDR_W-1:0] rdAddrA,
    output logic [ADDR_W-1:0] rdAddrB,
    input  logic [DATA_W-1:0] rdDataA,
    input  logic [DATA_W-1:0] rdDataB,
    input  logic              wb_writeEN,
    input  logic [ADDR_W-1:0] wb_wrAddr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_opcode,
    output logic [DATA_W-1:0] out_opA,
    output logic [DATA_W-1:0] out_opB,
    output logic [DATA_W-1:0] out_imm,
    output logic [ADDR_W-1:0] out_dest,
    output logic              out_wen,
    output logic              out_setcc,
    output logic [2:0]        out_nzp,
    output logic [DATA_W-1:0] out_pc,
    output logic              out_illegal
);

    opcode_e             op;
    logic                is_store;
    logic                uses_a;
    logic                uses_b;
    logic                haz_a;
    logic                haz_b;
    logic                accept;
    logic                retire;
    logic [NUM_REGS-1:0] busy;
    dec_rec_t            rec;
    dec_rec_t            rec_next;

    assign op       = opcode_e'(in_instr[15:12]);
    assign is_store = (op == OP_ST) || (op == OP_STI) || (op == OP_STR);
    assign uses_a   = (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LDR) ||
                      (op == OP_STR) || (op == OP_JMP) || (op == OP_JSR && !in_instr[11]);
    assign uses_b   = ((op == OP_ADD || op == OP_AND) && !in_instr[5]) || is_store;

    // Stores read their data register through port B.
    assign rdAddrA = in_instr[8:6];
    assign rdAddrB = is_store ? in_instr[11:9] : in_instr[2:0];

    // The held record's destination counts as pending before it has retired.
    assign haz_a = uses_a && (busy[rdAddrA] || (out_valid && rec.wen && rec.dest == rdAddrA));
    assign haz_b = uses_b && (busy[rdAddrB] || (out_valid && rec.wen && rec.dest == rdAddrB));

    assign in_ready = !rst && !flush && !haz_a && !haz_b && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign retire   = out_valid && out_ready && !flush;

    always_comb begin
        rec_next        = '0;
        rec_next.opcode = op;
        rec_next.op_a   = rdDataA;
        rec_next.op_b   = rdDataB;
        rec_next.pc     = in_pc;
        case (op)
            OP_ADD, OP_AND: begin
                rec_next.imm   = sext(DATA_W'(in_instr[IMM5_W-1:0]), IMM5_W);
                rec_next.dest  = in_instr[11:9];
                rec_next.wen   = 1'b1;
                rec_next.setcc = 1'b1;
                if (in_instr[5]) rec_next.op_b = rec_next.imm;
            end
            OP_NOT: begin
                rec_next.dest  = in_instr[11:9];
                rec_next.wen   = 1'b1;
                rec_next.setcc = 1'b1;
            end
            OP_LD, OP_LDI: begin
                rec_next.imm   = sext(DATA_W'(in_instr[OFF9_W-1:0]), OFF9_W);
                rec_next.dest  = in_instr[11:9];
                rec_next.wen   = 1'b1;
                rec_next.setcc = 1'b1;
            end
            OP_LDR: begin
                rec_next.imm   = sext(DATA_W'(in_instr[OFF6_W-1:0]), OFF6_W);
                rec_next.dest  = in_instr[11:9];
                rec_next.wen   = 1'b1;
                rec_next.setcc = 1'b1;
            end
            OP_LEA: begin
                rec_next.imm  = sext(DATA_W'(in_instr[OFF9_W-1:0]), OFF9_W);
                rec_next.dest = in_instr[11:9];
                rec_next.wen  = 1'b1;
            end
            OP_ST, OP_STI: rec_next.imm = sext(DATA_W'(in_instr[OFF9_W-1:0]), OFF9_W);
            OP_STR:        rec_next.imm = sext(DATA_W'(in_instr[OFF6_W-1:0]), OFF6_W);
            OP_BR: begin
                rec_next.imm = sext(DATA_W'(in_instr[OFF9_W-1:0]), OFF9_W);
                rec_next.nzp = in_instr[11:9];
            end
            OP_JSR: begin
                rec_next.dest = LINK_REG;
                rec_next.wen  = 1'b1;
                if (in_instr[11]) rec_next.imm = sext(DATA_W'(in_instr[OFF11_W-1:0]), OFF11_W);
            end
            OP_TRAP: begin
                rec_next.imm  = DATA_W'(in_instr[TRAP8_W-1:0]);
                rec_next.dest = LINK_REG;
                rec_next.wen  = 1'b1;
            end
            OP_RTI, OP_RES: rec_next.illegal = 1'b1;
            default: ;
        endcase
    end

    // Accept never coincides with flush, so the squash only needs to drop valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rec       <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            rec       <= rec_next;
            out_valid <= 1'b1;
        end else if (flush || retire) begin
            out_valid <= 1'b0;
        end
    end

    lc3_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (retire && rec.wen),
        .set_addr (rec.dest),
        .clr_en   (wb_writeEN),
        .clr_addr (wb_wrAddr),
        .busy     (busy)
    );

    assign out_opcode  = rec.opcode;
    assign out_opA     = rec.op_a;
    assign out_opB     = rec.op_b;
    assign out_imm     = rec.imm;
    assign out_dest    = rec.dest;
    assign out_wen     = rec.wen;
    assign out_setcc   = rec.setcc;
    assign out_nzp     = rec.nzp;
    assign out_pc      = rec.pc;
    assign out_illegal = rec.illegal;

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Directed bench for lc3_decode_stage: a small register-file model feeds the
// read ports and a queue of expected records is checked as records appear.
module tb_lc3_decode_stage;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [15:0] op_a;
        logic [15:0] op_b;
        logic [15:0] imm;
        logic [2:0]  dest;
        logic        wen;
        logic        setcc;
        logic [2:0]  nzp;
        logic [15:0] pc;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic [2:0]  rdAddrA;
    logic [2:0]  rdAddrB;
    logic [15:0] rdDataA;
    logic [15:0] rdDataB;
    logic        wb_writeEN;
    logic [2:0]  wb_wrAddr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [15:0] out_opA;
    logic [15:0] out_opB;
    logic [15:0] out_imm;
    logic [2:0]  out_dest;
    logic        out_wen;
    logic        out_setcc;
    logic [2:0]  out_nzp;
    logic [15:0] out_pc;
    logic        out_illegal;

    logic [15:0] regs [8];
    exp_t        exp_q [$];
    int          n_vec  = 0;
    int          n_miss = 0;

    assign rdDataA = regs[rdAddrA];
    assign rdDataB = regs[rdAddrB];

    always #5 clk = ~clk;

    lc3_decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .rdAddrA     (rdAddrA),
        .rdAddrB     (rdAddrB),
        .rdDataA     (rdDataA),
        .rdDataB     (rdDataB),
        .wb_writeEN  (wb_writeEN),
        .wb_wrAddr   (wb_wrAddr),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_opA     (out_opA),
        .out_opB     (out_opB),
        .out_imm     (out_imm),
        .out_dest    (out_dest),
        .out_wen     (out_wen),
        .out_setcc   (out_setcc),
        .out_nzp     (out_nzp),
        .out_pc      (out_pc),
        .out_illegal (out_illegal)
    );

    // Reference decode of one instruction against the current register model.
    function automatic exp_t model(input logic [15:0] i, input logic [15:0] pc);
        exp_t e;
        logic [3:0] op;
        op       = i[15:12];
        e        = '0;
        e.opcode = op;
        e.pc     = pc;
        e.op_a   = regs[i[8:6]];
        e.op_b   = (op == 4'h3 || op == 4'hB || op == 4'h7) ? regs[i[11:9]] : regs[i[2:0]];
        case (op)
            4'h1, 4'h5:                      e.imm = {{11{i[4]}}, i[4:0]};
            4'h6, 4'h7:                      e.imm = {{10{i[5]}}, i[5:0]};
            4'h0, 4'h2, 4'h3, 4'hA, 4'hB, 4'hE: e.imm = {{7{i[8]}}, i[8:0]};
            4'h4:                            e.imm = i[11] ? {{5{i[10]}}, i[10:0]} : 16'h0000;
            4'hF:                            e.imm = {8'h00, i[7:0]};
            default:                         e.imm = 16'h0000;
        endcase
        if ((op == 4'h1 || op == 4'h5) && i[5]) e.op_b = e.imm;
        if (op == 4'h1 || op == 4'h5 || op == 4'h9 || op == 4'h2 || op == 4'hA ||
            op == 4'h6 || op == 4'hE) begin
            e.dest = i[11:9];
            e.wen  = 1'b1;
        end else if (op == 4'h4 || op == 4'hF) begin
            e.dest = 3'd7;
            e.wen  = 1'b1;
        end
        e.setcc   = (op == 4'h1 || op == 4'h5 || op == 4'h9 || op == 4'h2 ||
                     op == 4'hA || op == 4'h6);
        e.nzp     = (op == 4'h0) ? i[11:9] : 3'b000;
        e.illegal = (op == 4'h8 || op == 4'hD);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_rec(input string tag, input bit pop);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $error("FAIL %s: observed record with nothing queued, expected a queued record", tag);
            return;
        end
        e = pop ? exp_q.pop_front() : exp_q[0];
        check({tag, ".valid"},   16'(out_valid),   16'h0001);
        check({tag, ".opcode"},  16'(out_opcode),  16'(e.opcode));
        check({tag, ".opA"},     out_opA,          e.op_a);
        check({tag, ".opB"},     out_opB,          e.op_b);
        check({tag, ".imm"},     out_imm,          e.imm);
        check({tag, ".dest"},    16'(out_dest),    16'(e.dest));
        check({tag, ".wen"},     16'(out_wen),     16'(e.wen));
        check({tag, ".setcc"},   16'(out_setcc),   16'(e.setcc));
        check({tag, ".nzp"},     16'(out_nzp),     16'(e.nzp));
        check({tag, ".pc"},      out_pc,           e.pc);
        check({tag, ".illegal"}, 16'(out_illegal), 16'(e.illegal));
    endtask

    // Present an instruction, wait (bounded) for acceptance, queue its expectation.
    task automatic send(input logic [15:0] instr, input logic [15:0] pc);
        int budget;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        #1;
        for (budget = 0; budget < 20 && !in_ready; budget++) tick();
        check("accept_wait", 16'(in_ready), 16'h0001);
        if (in_ready) exp_q.push_back(model(instr, pc));
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 8; r++) regs[r] = 16'h0000;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_instr   = 16'h0000;
        in_pc      = 16'h0000;
        wb_writeEN = 1'b0;
        wb_wrAddr  = 3'd0;
        flush      = 1'b0;
        out_ready  = 1'b0;

        // Reset held for two edges.
        tick();
        tick();
        check("rst.out_valid", 16'(out_valid), 16'h0000);
        check("rst.out_opB",   out_opB,        16'h0000);
        check("rst.out_dest",  16'(out_dest),  16'h0000);
        check("rst.busy",      16'(dut.u_scoreboard.busy), 16'h0000);
        check("rst.in_ready",  16'(in_ready),  16'h0000);
        rst = 1'b0;
        #1;
        check("post_rst.in_ready", 16'(in_ready), 16'h0001);

        // ADD R2,R1,#-3 with R1=5.
        regs[1] = 16'h0005;
        send(16'h147D, 16'h3001);
        check_rec("add_imm", 1'b0);

        // ADD R3,R2,R2 must wait for R2's writeback.
        in_valid  = 1'b1;
        in_instr  = 16'h1682;
        in_pc     = 16'h3002;
        out_ready = 1'b1;
        #1;
        check("haz_held_dest.in_ready", 16'(in_ready), 16'h0000);
        void'(exp_q.pop_front());
        tick();
        check("retire.out_valid", 16'(out_valid), 16'h0000);
        check("retire.busy", 16'(dut.u_scoreboard.busy), 16'h0004);
        check("haz_busy.in_ready", 16'(in_ready), 16'h0000);
        tick();
        check("haz_busy2.in_ready", 16'(in_ready), 16'h0000);
        wb_writeEN = 1'b1;
        wb_wrAddr  = 3'd2;
        regs[2]    = 16'h0007;
        #1;
        check("haz_wb_cycle.in_ready", 16'(in_ready), 16'h0000);
        tick();
        wb_writeEN = 1'b0;
        #1;
        check("after_wb.in_ready", 16'(in_ready), 16'h0001);
        exp_q.push_back(model(16'h1682, 16'h3002));
        out_ready = 1'b0;
        tick();
        check_rec("add_reg", 1'b0);

        // Back-pressure: record held stable for three cycles.
        in_valid = 1'b1;
        in_instr = 16'h5020;
        in_pc    = 16'h3003;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall.in_ready", 16'(in_ready), 16'h0000);
            check_rec("held", 1'b0);
            tick();
        end
        // Retire R3 while writeback clears R3 in the same cycle: set must win.
        out_ready  = 1'b1;
        wb_writeEN = 1'b1;
        wb_wrAddr  = 3'd3;
        #1;
        check("release.in_ready", 16'(in_ready), 16'h0001);
        void'(exp_q.pop_front());
        exp_q.push_back(model(16'h5020, 16'h3003));
        tick();
        wb_writeEN = 1'b0;
        in_valid   = 1'b0;
        check("set_wins.busy", 16'(dut.u_scoreboard.busy), 16'h0008);
        check_rec("and_imm", 1'b0);

        // Flush squashes AND R0 with out_ready high; R0 must not become busy.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 16'h0E05;
        in_pc    = 16'h3004;
        #1;
        check("flush.in_ready", 16'(in_ready), 16'h0000);
        tick();
        flush = 1'b0;
        check("flush.out_valid", 16'(out_valid), 16'h0000);
        check("flush.busy", 16'(dut.u_scoreboard.busy), 16'h0008);
        void'(exp_q.pop_front());

        // Streaming through the remaining formats with execute always ready.
        regs[5] = 16'h1234;
        send(16'h0E05, 16'h3004); check_rec("br",    1'b1);
        send(16'h6E7F, 16'h3005); check_rec("ldr",   1'b1);
        send(16'h3A05, 16'h3006); check_rec("st",    1'b1);
        send(16'h7A7F, 16'h3007); check_rec("str",   1'b1);
        send(16'h4FFF, 16'h3008); check_rec("jsr",   1'b1);
        send(16'hF025, 16'h3009); check_rec("trap",  1'b1);
        send(16'hD000, 16'h300A); check_rec("res",   1'b1);
        send(16'h8000, 16'h300B); check_rec("rti",   1'b1);
        tick();
        check("stream.busy", 16'(dut.u_scoreboard.busy), 16'h0088);

        // Reset while a record is held drops it and all pending busy bits.
        out_ready = 1'b0;
        send(16'h5260, 16'h300C);
        check_rec("and_hold", 1'b1);
        rst = 1'b1;
        tick();
        check("mid_rst.out_valid", 16'(out_valid), 16'h0000);
        check("mid_rst.out_opA",   out_opA,        16'h0000);
        check("mid_rst.out_pc",    out_pc,         16'h0000);
        check("mid_rst.busy",      16'(dut.u_scoreboard.busy), 16'h0000);
        rst = 1'b0;
        #1;
        check("mid_rst.in_ready", 16'(in_ready), 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
